sim_iserdes_multilane: RTL and testbench

Parametrised, single-clock behavioural deserializer model for simulation. It replaces the empty ISERDESE2 stubs wherever the testbench needs real captured data. It shifts in one serial bit per lane per cycle and emits a DATA_WIDTH-bit parallel word per lane every DATA_WIDTH cycles. Each lane supports bitslip word alignment and, optionally, training-pattern auto-alignment.

---
 rtl/sim_iserdes_multilane_pkg.sv | 8 +
 rtl/sim_iserdes_multilane_if.sv | 14 +
 rtl/sim_iserdes_multilane_lane.sv | 88 ++++++++
 rtl/sim_iserdes_multilane.sv | 50 +++++
 tb/tb_sim_iserdes_multilane.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sim_iserdes_multilane_pkg.sv
// sim_serdes_pkg: shared align-state type, width limit and parameter check for the deserializer model
package sim_serdes_pkg;
  localparam int MAX_DATA_WIDTH = 8;
  typedef enum logic [1:0] {HUNT, SLIP, SETTLE, LOCKED} align_state_e;
  function automatic bit width_ok(input int w);
    return w >= 2 && w <= MAX_DATA_WIDTH;
  endfunction
endpackage

// File: rtl/sim_iserdes_multilane_if.sv
// sim_iserdes_multilane_if: serial inputs, slip/align controls and parallel outputs of all lanes
interface sim_iserdes_multilane_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 4
);
  logic [NUM_LANES-1:0]            D;
  logic [NUM_LANES-1:0]            BITSLIP;
  logic                            ALIGN_EN;
  logic [NUM_LANES*DATA_WIDTH-1:0] Q;
  logic                            Q_VALID;
  logic [NUM_LANES-1:0]            LOCKED;
  modport master (output D, BITSLIP, ALIGN_EN, input Q, Q_VALID, LOCKED);
  modport slave  (input D, BITSLIP, ALIGN_EN, output Q, Q_VALID, LOCKED);
endinterface

// File: rtl/sim_iserdes_multilane_lane.sv
// sim_serdes_lane: one lane's shift register, slip offset, pending slip and optional auto-align FSM
module sim_serdes_lane
  import sim_serdes_pkg::*;
#(
  parameter int         W             = 8,
  parameter int         MSB_FIRST     = 1,
  parameter logic [7:0] TRAIN_PATTERN = 8'h5C,
  parameter int         LOCK_COUNT    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         d,
  input  logic         bitslip,
  input  logic         align_en,
  input  logic         bnd,
  output logic [W-1:0] q,
  output logic         locked
);
  localparam int SW = $clog2(W);
  logic [2*W-1:0] sr_q, sr_d;
  logic [SW-1:0]  s_q, s_d;
  logic           pend_q, pend_d, slip_req;
  logic [W-1:0]   q_q, q_d, win, word;
  // sr_q[0] is the newest bit; the word window sits s bits behind it
  always_comb begin
    sr_d   = {sr_q[2*W-2:0], d};
    win    = sr_q[s_q +: W];
    word   = MSB_FIRST != 0 ? win : {<<{win}};
    q_d    = bnd ? word : q_q;
    s_d    = bnd && pend_q ? (s_q == SW'(W-1) ? '0 : s_q + 1'b1) : s_q;
    pend_d = slip_req || (pend_q && !bnd);
  end
  always_ff @(posedge clk)
    if (rst) begin
      sr_q   <= '0;
      s_q    <= '0;
      pend_q <= 1'b0;
      q_q    <= '0;
    end else begin
      sr_q   <= sr_d;
      s_q    <= s_d;
      pend_q <= pend_d;
      q_q    <= q_d;
    end
  assign q = q_q;
`ifdef SIM_SERDES_AUTO_ALIGN_EN
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [W-1:0] PAT = TRAIN_PATTERN[W-1:0];
  align_state_e st_q;
  logic [MW-1:0] mc_q;
  logic          sc_q, locked_q;
  always_ff @(posedge clk)
    if (rst || !align_en) begin
      st_q     <= HUNT;
      mc_q     <= '0;
      sc_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      case (st_q)
        HUNT:
          if (bnd) begin
            if (word != PAT) begin
              mc_q <= '0;
              st_q <= SLIP;
            end else if (mc_q == MW'(LOCK_COUNT - 1)) begin
              mc_q     <= '0;
              st_q     <= LOCKED;
              locked_q <= 1'b1;
            end else mc_q <= mc_q + 1'b1;
          end
        SLIP: st_q <= SETTLE;
        SETTLE:
          if (bnd) begin
            sc_q <= !sc_q;
            if (sc_q) st_q <= HUNT;
          end
        default: locked_q <= 1'b1;
      endcase
    end
  assign slip_req = align_en ? st_q == SLIP : bitslip;
  assign locked   = locked_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{align_en, TRAIN_PATTERN[W-1:0], LOCK_COUNT[0]};
  assign slip_req   = bitslip;
  assign locked     = 1'b0;
`endif
endmodule

// File: rtl/sim_iserdes_multilane.sv
// sim_iserdes_multilane: multi-lane behavioural deserializer; SIM_SERDES_AUTO_ALIGN_EN adds per-lane training auto-align
module sim_iserdes_multilane
  import sim_serdes_pkg::*;
#(
  parameter int         DATA_WIDTH    = 8,
  parameter int         NUM_LANES     = 4,
  parameter int         MSB_FIRST     = 1,
  parameter logic [7:0] TRAIN_PATTERN = 8'h5C,
  parameter int         LOCK_COUNT    = 4
) (
  input logic                   CLK,
  input logic                   RST,
  sim_iserdes_multilane_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH);
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic                            bnd_q, bnd_d, q_valid_q, q_valid_d;
  logic [NUM_LANES*DATA_WIDTH-1:0] q_all;
  logic [NUM_LANES-1:0]            locked_all;
  if (!width_ok(DATA_WIDTH) || NUM_LANES < 1) begin : g_bad_cfg
    $error("sim_iserdes_multilane: DATA_WIDTH must be 2..8 and NUM_LANES >= 1");
  end
  // bnd_q marks the cycle after the last bit of a word was captured
  always_comb begin
    bnd_d     = cnt_q == CW'(DATA_WIDTH - 1);
    cnt_d     = bnd_d ? '0 : cnt_q + 1'b1;
    q_valid_d = bnd_q;
  end
  always_ff @(posedge CLK)
    if (RST) begin
      cnt_q     <= '0;
      bnd_q     <= 1'b0;
      q_valid_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bnd_q     <= bnd_d;
      q_valid_q <= q_valid_d;
    end
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    sim_serdes_lane #(
      .W(DATA_WIDTH), .MSB_FIRST(MSB_FIRST), .TRAIN_PATTERN(TRAIN_PATTERN), .LOCK_COUNT(LOCK_COUNT)
    ) u_lane (
      .clk(CLK), .rst(RST), .d(bus.D[i]), .bitslip(bus.BITSLIP[i]), .align_en(bus.ALIGN_EN),
      .bnd(bnd_q), .q(q_all[i*DATA_WIDTH +: DATA_WIDTH]), .locked(locked_all[i])
    );
  end
  assign bus.Q       = q_all;
  assign bus.Q_VALID = q_valid_q;
  assign bus.LOCKED  = locked_all;
endmodule

// File: tb/tb_sim_iserdes_multilane.sv
// tb_sim_iserdes_multilane: randomized bench against a bit-history reference model of the deserializer
module tb_sim_iserdes_multilane;
  localparam int W = 8, NL = 4;
  logic clk = 1'b0, rst;
  always #5 clk = ~clk;
  sim_iserdes_multilane_if #(.DATA_WIDTH(W), .NUM_LANES(NL)) b0(), b1();
  assign b1.D = b0.D;
  assign b1.BITSLIP = b0.BITSLIP;
  assign b1.ALIGN_EN = b0.ALIGN_EN;
  sim_iserdes_multilane #(.DATA_WIDTH(W), .NUM_LANES(NL), .MSB_FIRST(1), .TRAIN_PATTERN(8'h5C), .LOCK_COUNT(4))
    dut (.CLK(clk), .RST(rst), .bus(b0.slave));
  sim_iserdes_multilane #(.DATA_WIDTH(W), .NUM_LANES(NL), .MSB_FIRST(0), .TRAIN_PATTERN(8'h5C), .LOCK_COUNT(4))
    dut_l (.CLK(clk), .RST(rst), .bus(b1.slave));

  int pass_n = 0, tot_n = 0;
  bit hist[NL][$];
  int s_m[NL];
  bit slip_w[NL];
  int bit_t, nstrobe;
  bit model_on;
  int mode[NL];
  logic [7:0] pat[NL];
  int skw[NL];
  logic [W-1:0] last_q[NL];

  // word j of the stream, read s bits late, first-received bit in MSB (msb=1) or LSB
  function automatic logic [W-1:0] model_word(int l, int j, bit msb);
    logic [W-1:0] r;
    int b;
    r = '0;
    for (int i = 0; i < W; i++) begin
      b = j * W + i - s_m[l];
      if (b >= 0 && hist[l][b]) r[msb ? W-1-i : i] = 1'b1;
    end
    return r;
  endfunction

  task automatic cycle(input logic [NL-1:0] sl);
    logic [NL-1:0] dv;
    logic [NL*W-1:0] e0, e1;
    bit emit;
    for (int l = 0; l < NL; l++)
      dv[l] = mode[l] == 1 ? pat[l][7 - ((bit_t + skw[l]) % 8)] : 1'($urandom);
    b0.D = dv;
    b0.BITSLIP = sl;
    @(posedge clk);
    emit = bit_t > 0 && bit_t % W == 0;
    e0 = '0;
    e1 = '0;
    for (int l = 0; l < NL; l++) begin
      if (emit) begin
        e0[l*W +: W] = model_word(l, bit_t / W - 1, 1'b1);
        e1[l*W +: W] = model_word(l, bit_t / W - 1, 1'b0);
        if (slip_w[l]) s_m[l] = (s_m[l] + 1) % W;
        slip_w[l] = 1'b0;
      end
      if (sl[l]) slip_w[l] = 1'b1;
      hist[l].push_back(dv[l]);
    end
    bit_t++;
    #1;
    tot_n++;
    if (b0.Q_VALID !== emit) $display("FAIL q_valid edge %0d: got %b want %b", bit_t, b0.Q_VALID, emit);
    else pass_n++;
    if (emit) begin
      nstrobe++;
      for (int l = 0; l < NL; l++) last_q[l] = b0.Q[l*W +: W];
      if (model_on) begin
        tot_n++;
        if (b0.Q !== e0) $display("FAIL q_msb edge %0d: got %h want %h", bit_t, b0.Q, e0);
        else pass_n++;
        tot_n++;
        if (b1.Q !== e1) $display("FAIL q_lsb edge %0d: got %h want %h", bit_t, b1.Q, e1);
        else pass_n++;
        tot_n++;
        if (b0.LOCKED !== '0) $display("FAIL locked_idle edge %0d: got %b want 0", bit_t, b0.LOCKED);
        else pass_n++;
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    b0.BITSLIP = '0;
    b0.ALIGN_EN = 1'b0;
    model_on = 1'b1;
    for (int k = 0; k < n; k++) begin
      b0.D = NL'($urandom);
      @(posedge clk);
      #1;
      tot_n++;
      if (b0.Q !== '0 || b0.Q_VALID !== 1'b0 || b0.LOCKED !== '0)
        $display("FAIL reset_state: got q=%h v=%b lk=%b want 0", b0.Q, b0.Q_VALID, b0.LOCKED);
      else pass_n++;
    end
    rst = 1'b0;
    bit_t = 0;
    nstrobe = 0;
    for (int l = 0; l < NL; l++) begin
      hist[l].delete();
      s_m[l] = 0;
      slip_w[l] = 1'b0;
    end
  endtask

  task automatic run_strobes(input int n, input logic [NL-1:0] sl, output int cyc);
    int tgt;
    tgt = nstrobe + n;
    cyc = 0;
    while (nstrobe < tgt && cyc < (n + 2) * W) begin
      cycle(sl);
      cyc++;
    end
    if (nstrobe < tgt) begin
      tot_n++;
      $display("FAIL strobe_timeout: got %0d strobes want %0d", nstrobe, tgt);
    end
  endtask

  task automatic set_lanes(input int m, input logic [7:0] p);
    for (int l = 0; l < NL; l++) begin
      mode[l] = m;
      pat[l] = p;
      skw[l] = 0;
    end
  endtask

  task automatic first_strobe(input string name);
    int edges;
    edges = 0;
    while (b0.Q_VALID !== 1'b1 && edges < 20) begin
      cycle('0);
      edges++;
    end
    tot_n++;
    if (edges != W + 1) $display("FAIL %s: first strobe at edge %0d want %0d", name, edges, W + 1);
    else pass_n++;
  endtask

  task automatic test_reset;
    int cyc;
    set_lanes(0, 8'h00);
    do_reset(3);
    first_strobe("first_strobe");
    for (int k = 0; k < 3; k++) begin
      run_strobes(1, '0, cyc);
      tot_n++;
      if (cyc != W) $display("FAIL strobe_period: got %0d want %0d", cyc, W);
      else pass_n++;
    end
  endtask

  task automatic test_data_path;
    int cyc;
    set_lanes(0, 8'h00);
    mode[0] = 1;
    pat[0] = 8'hA5;
    do_reset(2);
    for (int k = 0; k < 5; k++) begin
      run_strobes(1, '0, cyc);
      tot_n++;
      if (last_q[0] !== 8'hA5 || b1.Q[7:0] !== 8'hA5)
        $display("FAIL data_a5: got msb=%h lsb=%h want a5", last_q[0], b1.Q[7:0]);
      else pass_n++;
    end
  endtask

  task automatic test_bitslip;
    int cyc;
    set_lanes(1, 8'hA5);
    do_reset(2);
    run_strobes(2, '0, cyc);
    cycle(4'b0010);
    run_strobes(2, '0, cyc);
    tot_n++;
    if (last_q[1] !== 8'hD2 || last_q[0] !== 8'hA5)
      $display("FAIL slip_one: got l1=%h l0=%h want d2 a5", last_q[1], last_q[0]);
    else pass_n++;
    for (int k = 0; k < 7; k++) begin
      cycle(4'b0010);
      run_strobes(1, '0, cyc);
    end
    run_strobes(1, '0, cyc);
    tot_n++;
    if (last_q[1] !== 8'hA5 || last_q[0] !== 8'hA5)
      $display("FAIL slip_wrap: got l1=%h l0=%h want a5 a5", last_q[1], last_q[0]);
    else pass_n++;
  endtask

  task automatic test_collapse;
    int cyc;
    set_lanes(1, 8'hA5);
    do_reset(2);
    run_strobes(2, '0, cyc);
    cycle(4'b0010);
    cycle('0);
    cycle(4'b0010);
    run_strobes(2, '0, cyc);
    tot_n++;
    if (last_q[1] !== 8'hD2) $display("FAIL collapse: got %h want d2", last_q[1]);
    else pass_n++;
    run_strobes(1, '0, cyc);
    tot_n++;
    if (last_q[1] !== 8'hD2) $display("FAIL collapse_hold: got %h want d2", last_q[1]);
    else pass_n++;
  endtask

  task automatic test_back_to_back;
    logic [NL-1:0] sl;
    set_lanes(0, 8'h00);
    do_reset(2);
    for (int k = 0; k < 30 * W; k++) begin
      for (int l = 0; l < NL; l++) sl[l] = $urandom_range(4) == 0;
      cycle(sl);
    end
  endtask

`ifdef SIM_SERDES_AUTO_ALIGN_EN
  task automatic test_auto_align;
    int cyc, k;
    set_lanes(0, 8'h00);
    mode[2] = 1;
    pat[2] = 8'h5C;
    skw[2] = 3;
    do_reset(2);
    model_on = 1'b0;
    b0.ALIGN_EN = 1'b1;
    k = 0;
    while (b0.LOCKED[2] !== 1'b1 && k < 40) begin
      run_strobes(1, '0, cyc);
      k++;
    end
    tot_n++;
    if (b0.LOCKED[2] !== 1'b1) $display("FAIL lock_lane2: got %b want 1", b0.LOCKED[2]);
    else pass_n++;
    for (int n = 0; n < 6; n++) begin
      run_strobes(1, 4'b0100, cyc);
      tot_n++;
      if (last_q[2] !== 8'h5C || b0.LOCKED[2] !== 1'b1)
        $display("FAIL locked_data: got q=%h lk=%b want 5c 1", last_q[2], b0.LOCKED[2]);
      else pass_n++;
    end
    b0.ALIGN_EN = 1'b0;
    cycle('0);
    tot_n++;
    if (b0.LOCKED !== '0) $display("FAIL unlock: got %b want 0", b0.LOCKED);
    else pass_n++;
  endtask

  task automatic test_mid_reset;
    int cyc, k;
    set_lanes(1, 8'h5C);
    for (int l = 0; l < NL; l++) skw[l] = l;
    do_reset(2);
    model_on = 1'b0;
    b0.ALIGN_EN = 1'b1;
    k = 0;
    while (b0.LOCKED !== 4'hF && k < 60) begin
      run_strobes(1, '0, cyc);
      k++;
    end
    tot_n++;
    if (b0.LOCKED !== 4'hF) $display("FAIL lock_all: got %b want 1111", b0.LOCKED);
    else pass_n++;
    cycle('0);
    cycle('0);
    set_lanes(1, 8'hA5);
    do_reset(1);
    first_strobe("restart_strobe");
    tot_n++;
    if (last_q[0] !== 8'hA5 || last_q[3] !== 8'hA5)
      $display("FAIL restart_offset: got l0=%h l3=%h want a5", last_q[0], last_q[3]);
    else pass_n++;
  endtask
`else
  task automatic test_mid_reset;
    int cyc;
    set_lanes(1, 8'hA5);
    do_reset(2);
    run_strobes(1, '0, cyc);
    cycle(4'b0010);
    run_strobes(1, '0, cyc);
    cycle(4'b1010);
    run_strobes(1, '0, cyc);
    cycle('0);
    cycle('0);
    do_reset(1);
    first_strobe("restart_strobe");
    tot_n++;
    if (last_q[1] !== 8'hA5 || last_q[3] !== 8'hA5)
      $display("FAIL restart_offset: got l1=%h l3=%h want a5", last_q[1], last_q[3]);
    else pass_n++;
  endtask
`endif

  initial begin
    rst = 1'b1;
    b0.D = '0;
    b0.BITSLIP = '0;
    b0.ALIGN_EN = 1'b0;
    test_reset;
    test_data_path;
    test_bitslip;
    test_collapse;
    test_back_to_back;
`ifdef SIM_SERDES_AUTO_ALIGN_EN
    test_auto_align;
`endif
    test_mid_reset;
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
